dtmr_ctrl: RTL

Sequential controller for the Dynamic TMR datapath. It decides when the three-copy voter runs in voting mode and drives the voter's `state` input. It consumes the voter's per-copy `fault` flags, filters them over consecutive cycles, and pulses a reset into a copy that keeps disagreeing. A copy that does not recover after repeated resets is retired, and the block flags loss of redundancy.

---
 rtl/dtmr_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dtmr_ctrl.sv
// rtl/dtmr_ctrl.sv - Dynamic TMR controller: mode selection, fault filtering, copy recovery and retirement
module dtmr_ctrl #(
  parameter int FAULT_LIMIT   = 4,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int RETRY_MAX     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crit_req,
  input  logic [2:0] fault,
  output logic       state,
  output logic [2:0] copy_rst,
  output logic [2:0] copy_dead,
  output logic [2:0] fault_seen,
  output logic       redund_lost
);

  localparam int FW  = ($clog2(FAULT_LIMIT + 1) < 1) ? 1 : $clog2(FAULT_LIMIT + 1);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW  = ($clog2(RETRY_MAX + 1) < 1) ? 1 : $clog2(RETRY_MAX + 1);

  localparam logic [FW-1:0]  FLIM  = FW'(FAULT_LIMIT);
  localparam logic [RCW-1:0] RLAST = RCW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]  SLAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0]  RMAX  = RW'(RETRY_MAX);

  typedef enum logic [1:0] {SIMPLEX, SETTLE, VOTE, RECOVER} fsm_t;

  fsm_t           fsm;
  logic [FW-1:0]  fcnt  [3];
  logic [RW-1:0]  retry [3];
  logic [RCW-1:0] rcnt;
  logic [SW-1:0]  scnt;

  logic [FW-1:0]  nf [3];
  logic [2:0]     hit;
  logic [1:0]     sel;
  logic           any_hit;
  logic           can_retry;

  // Next fault counts as they would be after this VOTE cycle; the limit is
  // detected on the cycle the last fault is sampled so recovery starts next cycle.
  always_comb begin
    hit = '0;
    sel = '0;
    for (int k = 0; k < 3; k++) begin
      if (fault[k] && !copy_dead[k])
        nf[k] = (fcnt[k] == FLIM) ? FLIM : fcnt[k] + 1'b1;
      else
        nf[k] = '0;
      hit[k] = (nf[k] == FLIM);
    end
    for (int k = 2; k >= 0; k--)
      if (hit[k]) sel = 2'(k);
    any_hit   = |hit;
    can_retry = (retry[sel] < RMAX) && !redund_lost;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= SIMPLEX;
      state       <= 1'b0;
      copy_rst    <= '0;
      copy_dead   <= '0;
      fault_seen  <= '0;
      redund_lost <= 1'b0;
      rcnt        <= '0;
      scnt        <= '0;
      for (int k = 0; k < 3; k++) begin
        fcnt[k]  <= '0;
        retry[k] <= '0;
      end
    end else begin
      redund_lost <= ($countones(copy_dead) >= 2);
      case (fsm)
        SIMPLEX: begin
          for (int k = 0; k < 3; k++) fcnt[k] <= '0;
          if (crit_req) begin
            fsm   <= SETTLE;
            state <= 1'b1;
            scnt  <= '0;
          end
        end
        SETTLE: begin
          if (!crit_req) begin
            fsm   <= SIMPLEX;
            state <= 1'b0;
          end else if (scnt == SLAST) begin
            fsm <= VOTE;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        VOTE: begin
          fault_seen <= fault_seen | (fault & ~copy_dead);
          for (int k = 0; k < 3; k++) fcnt[k] <= nf[k];
          if (any_hit) begin
            if (can_retry) begin
              retry[sel] <= retry[sel] + 1'b1;
              for (int k = 0; k < 3; k++) fcnt[k] <= '0;
              copy_rst <= 3'b001 << sel;
              rcnt     <= '0;
              fsm      <= RECOVER;
            end else begin
              copy_dead[sel] <= 1'b1;
              fcnt[sel]      <= '0;
            end
          end else if (!crit_req) begin
            for (int k = 0; k < 3; k++) fcnt[k] <= '0;
            fsm   <= SIMPLEX;
            state <= 1'b0;
          end
        end
        RECOVER: begin
          if (rcnt == RLAST) begin
            copy_rst <= '0;
            scnt     <= '0;
            fsm      <= SETTLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          fsm   <= SIMPLEX;
          state <= 1'b0;
        end
      endcase
    end
  end

endmodule
